// File: rtl/mem_fill_controller.sv
// Block-fill engine: issues one memory request per miss, gathers NUM_BEATS wrap-ordered
// beats into their absolute slots, and retries a silent memory a bounded number of times.
module mem_fill_controller #(
    parameter int ADDR_WIDTH     = 16,
    parameter int BEAT_WIDTH     = 40,
    parameter int NUM_BEATS      = 8,
    parameter int WORDS_P_BLOCK  = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 3,
    localparam int BLOCK_WIDTH   = BEAT_WIDTH * NUM_BEATS,
    localparam int BIW           = $clog2(NUM_BEATS),
    localparam int NWW           = $clog2(WORDS_P_BLOCK) + 1
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   i_halt,
    input  logic [ADDR_WIDTH-1:0]  i_block_addr,
    input  logic [BIW-1:0]         i_crit_beat,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
    output logic [BIW-1:0]         o_mem_req_beat,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    input  logic [BEAT_WIDTH-1:0]  i_mem_data,
    input  logic                   i_mem_data_valid,
    output logic                   o_mem_ready,
    output logic [BLOCK_WIDTH-1:0] o_block_data,
    output logic [NUM_BEATS-1:0]   o_beat_valid,
    output logic                   o_crit_valid,
    output logic [NWW-1:0]         o_num_words_rcvd,
    output logic                   o_fill_done,
    output logic                   o_fill_error
);

    localparam int WPB = WORDS_P_BLOCK / NUM_BEATS;
    localparam int CW  = BIW + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW  = $clog2(MAX_RETRIES + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RECV, S_DONE, S_ERR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BIW-1:0]        cbeat_q;
    logic [BIW-1:0]        ptr_q;
    logic [CW-1:0]         cnt_q;
    logic [TW-1:0]         tmr_q;
    logic [RW-1:0]         rty_q;
    logic [NUM_BEATS-1:0]  mask_q;
    logic [BEAT_WIDTH-1:0] slot_q [NUM_BEATS];
    logic                  crit_q;
    logic                  err_q;

    logic live, req_acc, mem_hs, beat_acc, timeout, can_retry;

    // Handshake outputs drop during halt and while reset is held.
    assign live            = arst_n & ~i_halt;
    assign o_req_ready     = live & (state_q == S_IDLE);
    assign o_mem_req_valid = live & (state_q == S_REQ);
    assign o_mem_req_addr  = (state_q == S_REQ) ? addr_q  : '0;
    assign o_mem_req_beat  = (state_q == S_REQ) ? cbeat_q : '0;
    assign o_mem_ready     = live & ((state_q == S_WAIT) | (state_q == S_RECV));
    assign o_fill_done     = arst_n & (state_q == S_DONE);
    assign o_fill_error    = err_q;
    assign o_crit_valid    = crit_q;
    assign o_beat_valid    = mask_q;
    assign o_num_words_rcvd = NWW'(cnt_q * WPB);

    assign req_acc   = o_req_ready & i_req_valid;
    assign mem_hs    = o_mem_req_valid & i_mem_req_ready;
    assign beat_acc  = o_mem_ready & i_mem_data_valid;
    assign timeout   = (tmr_q == TW'(TIMEOUT_CYCLES - 1));
    assign can_retry = (rty_q < RW'(MAX_RETRIES));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_acc) state_d = S_REQ;
            S_REQ:  if (mem_hs)  state_d = S_WAIT;
            S_WAIT: begin
                // A beat in the expiry cycle takes priority over the retry.
                if (beat_acc)     state_d = S_RECV;
                else if (timeout) state_d = can_retry ? S_REQ : S_ERR;
            end
            S_RECV: if (beat_acc && cnt_q == CW'(NUM_BEATS - 1)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cbeat_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            rty_q   <= '0;
            mask_q  <= '0;
            crit_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (!i_halt) begin
            state_q <= state_d;
            crit_q  <= (state_q == S_WAIT) && beat_acc;
            if (req_acc) begin
                addr_q  <= i_block_addr;
                cbeat_q <= i_crit_beat;
                ptr_q   <= i_crit_beat;
                cnt_q   <= '0;
                mask_q  <= '0;
                rty_q   <= '0;
                err_q   <= 1'b0;
            end
            if (mem_hs) tmr_q <= '0;
            if (state_q == S_WAIT) begin
                tmr_q <= tmr_q + TW'(1);
                if (!beat_acc && timeout && can_retry) rty_q <= rty_q + RW'(1);
            end
            if (beat_acc) begin
                mask_q[ptr_q] <= 1'b1;
                ptr_q         <= ptr_q + BIW'(1);
                cnt_q         <= cnt_q + CW'(1);
            end
            if (state_q == S_ERR) err_q <= 1'b1;
        end
    end

    // Slot g holds absolute beat g; wrap order only moves the write pointer.
    for (genvar g = 0; g < NUM_BEATS; g++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!arst_n)
                slot_q[g] <= '0;
            else if (!i_halt && beat_acc && ptr_q == BIW'(g))
                slot_q[g] <= i_mem_data;
        end
        assign o_block_data[g*BEAT_WIDTH +: BEAT_WIDTH] = slot_q[g];
    end

endmodule

// File: tb/tb_mem_fill_controller.sv
// Directed bench for mem_fill_controller: a slot/phase model driven by the stimulus thread,
// checked every cycle by one compare process, plus hand-computed literal checks.
module tb_mem_fill_controller;

    localparam int AW = 16, BW = 40, NB = 8, WPBLK = 16, TO = 64, MR = 3;
    localparam int BIW = $clog2(NB), BLKW = BW * NB, NWW = $clog2(WPBLK) + 1, WPB = WPBLK / NB;

    logic            clk = 1'b0, arst_n = 1'b0, i_halt = 1'b0;
    logic [AW-1:0]   i_block_addr = '0;
    logic [BIW-1:0]  i_crit_beat = '0;
    logic            i_req_valid = 1'b0, i_mem_req_ready = 1'b0, i_mem_data_valid = 1'b0;
    logic [BW-1:0]   i_mem_data = '0;
    logic            o_req_ready, o_mem_req_valid, o_mem_ready, o_crit_valid, o_fill_done, o_fill_error;
    logic [AW-1:0]   o_mem_req_addr;
    logic [BIW-1:0]  o_mem_req_beat;
    logic [BLKW-1:0] o_block_data;
    logic [NB-1:0]   o_beat_valid;
    logic [NWW-1:0]  o_num_words_rcvd;

    always #5 clk = ~clk;

    mem_fill_controller #(
        .ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .NUM_BEATS(NB), .WORDS_P_BLOCK(WPBLK),
        .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
        .i_block_addr(i_block_addr), .i_crit_beat(i_crit_beat),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .o_mem_req_addr(o_mem_req_addr), .o_mem_req_beat(o_mem_req_beat),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .i_mem_data(i_mem_data), .i_mem_data_valid(i_mem_data_valid), .o_mem_ready(o_mem_ready),
        .o_block_data(o_block_data), .o_beat_valid(o_beat_valid), .o_crit_valid(o_crit_valid),
        .o_num_words_rcvd(o_num_words_rcvd), .o_fill_done(o_fill_done), .o_fill_error(o_fill_error)
    );

    typedef enum {P_IDLE, P_REQ, P_MEM, P_DONE, P_ERR} ph_t;

    ph_t            ph = P_IDLE;
    bit             chk_en = 1'b0;
    logic [BW-1:0]  m_slot [NB];
    logic [NB-1:0]  m_mask;
    int             m_cnt;
    logic           m_err, m_crit;
    logic [AW-1:0]  m_addr;
    logic [BIW-1:0] m_cbeat, m_ptr;
    int             errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [BLKW-1:0] act, input logic [BLKW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] dv(input logic [7:0] tag, input int k);
        return {tag, 24'h5A5A5A, 8'(k)};
    endfunction

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        logic [BLKW-1:0] eb;
        bit live;
        if (chk_en) begin
            for (int k = 0; k < NB; k++) eb[k*BW +: BW] = m_slot[k];
            live = arst_n && !i_halt;
            chk("req_ready",     o_req_ready,      live && ph == P_IDLE);
            chk("mem_req_valid", o_mem_req_valid,  live && ph == P_REQ);
            chk("mem_req_addr",  o_mem_req_addr,   (ph == P_REQ) ? m_addr : '0);
            chk("mem_req_beat",  o_mem_req_beat,   (ph == P_REQ) ? m_cbeat : '0);
            chk("mem_ready",     o_mem_ready,      live && ph == P_MEM);
            chk("fill_done",     o_fill_done,      arst_n && ph == P_DONE);
            chk("fill_error",    o_fill_error,     m_err);
            chk("crit_valid",    o_crit_valid,     m_crit);
            chk("block_data",    o_block_data,     eb);
            chk("beat_valid",    o_beat_valid,     m_mask);
            chk("words_rcvd",    o_num_words_rcvd, m_cnt * WPB);
        end
    end

    task automatic m_clear();
        for (int k = 0; k < NB; k++) m_slot[k] = '0;
        m_mask = '0; m_cnt = 0; m_err = 1'b0; m_crit = 1'b0;
        m_addr = '0; m_cbeat = '0; m_ptr = '0; ph = P_IDLE;
    endtask

    // One clock; completion/error phases retire unless the edge was halted.
    task automatic tick();
        bit h;
        h = i_halt;
        @(posedge clk); #1;
        if (!h) begin
            m_crit = 1'b0;
            if (ph == P_DONE) ph = P_IDLE;
            else if (ph == P_ERR) begin ph = P_IDLE; m_err = 1'b1; end
        end
    endtask

    task automatic accept(input logic [AW-1:0] a, input logic [BIW-1:0] c);
        i_block_addr = a; i_crit_beat = c; i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        m_addr = a; m_cbeat = c; m_ptr = c; m_mask = '0; m_cnt = 0; m_err = 1'b0;
        ph = P_REQ;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [BIW-1:0] c);
        accept(a, c);
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        ph = P_MEM;
    endtask

    task automatic beat(input logic [BW-1:0] d);
        i_mem_data = d; i_mem_data_valid = 1'b1;
        tick();
        i_mem_data_valid = 1'b0;
        m_slot[m_ptr] = d; m_mask[m_ptr] = 1'b1; m_ptr = m_ptr + 1'b1; m_cnt++;
        if (m_cnt == 1) m_crit = 1'b1;
        if (m_cnt == NB) ph = P_DONE;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        int nreq, gap;
        m_clear();
        tick();                       // reset edge, arst_n still low
        chk_en = 1'b1;
        #1;
        chk("rst_req_ready", o_req_ready, 1'b0);
        chk("rst_block", o_block_data, '0);
        chk("rst_mask", o_beat_valid, '0);
        chk("rst_words", o_num_words_rcvd, '0);
        chk("rst_error", o_fill_error, 1'b0);
        arst_n = 1'b1;
        tick();

        // Crit 0, back-to-back beats.
        start(16'h1230, 3'd0);
        for (int k = 0; k < NB; k++) beat(dv(8'hD0, k));
        chk("t1_done_pulse", o_fill_done, 1'b1);
        tick();
        chk("t1_done_gone", o_fill_done, 1'b0);
        chk("t1_d0", o_block_data[39:0], 40'hD05A5A5A00);
        chk("t1_d7", o_block_data[319:280], 40'hD05A5A5A07);
        chk("t1_mask", o_beat_valid, 8'hFF);
        chk("t1_words", o_num_words_rcvd, 16);
        tick();

        // Crit 5: wrap order.
        start(16'h1240, 3'd5);
        beat(dv(8'hB0, 0));
        chk("t2_crit_pulse", o_crit_valid, 1'b1);
        beat(dv(8'hB0, 1));
        beat(dv(8'hB0, 2));
        chk("t2_mask3", o_beat_valid, 8'hE0);
        for (int k = 3; k < NB; k++) beat(dv(8'hB0, k));
        tick();
        chk("t2_b0_slot5", o_block_data[239:200], 40'hB05A5A5A00);
        chk("t2_b3_slot0", o_block_data[39:0], 40'hB05A5A5A03);
        tick();

        // Silent memory: 1 request + MR retries, then error.
        accept(16'h4440, 3'd3);
        i_mem_req_ready = 1'b1;
        nreq = 0;
        for (int r = 0; r <= MR; r++) begin
            ph = P_REQ;
            #1;
            if (o_mem_req_valid && o_mem_req_addr == 16'h4440 && o_mem_req_beat == 3'd3) nreq++;
            tick();
            ph = P_MEM;
            gap = 0;
            for (int k = 0; k < TO; k++) begin
                #1;
                if (!o_mem_req_valid) gap++;
                tick();
            end
            chk("t3_gap", gap, 64);
        end
        ph = P_ERR;
        i_mem_req_ready = 1'b0;
        tick();
        chk("t3_nreq", nreq, 4);
        chk("t3_error", o_fill_error, 1'b1);
        chk("t3_ready", o_req_ready, 1'b1);
        tick();

        // Beat in the 64th WAIT cycle wins over the retry.
        start(16'h5550, 3'd1);
        repeat (TO - 1) tick();
        beat(dv(8'hE0, 0));
        chk("t4_err_cleared", o_fill_error, 1'b0);
        chk("t4_mask1", o_beat_valid, 8'h02);
        for (int k = 1; k < NB; k++) beat(dv(8'hE0, k));
        tick();
        tick();

        // Halt for 10 cycles after three beats, data offered throughout.
        start(16'h6660, 3'd2);
        for (int k = 0; k < 3; k++) beat(dv(8'hC0, k));
        i_halt = 1'b1; i_mem_data = 40'hFFFFFFFFFF; i_mem_data_valid = 1'b1;
        #1;
        chk("t5_halt_mem_ready", o_mem_ready, 1'b0);
        repeat (10) tick();
        chk("t5_halt_mask", o_beat_valid, 8'h1C);
        i_halt = 1'b0; i_mem_data_valid = 1'b0;
        for (int k = 3; k < NB; k++) beat(dv(8'hC0, k));
        tick();
        chk("t5_slot2", o_block_data[119:80], 40'hC05A5A5A00);
        tick();

        // Reset after four beats aborts silently.
        start(16'h7770, 3'd6);
        for (int k = 0; k < 4; k++) beat(dv(8'hA0, k));
        arst_n = 1'b0;
        tick();
        m_clear();
        arst_n = 1'b1;
        #1;
        chk("t6_block", o_block_data, '0);
        chk("t6_mask", o_beat_valid, '0);
        chk("t6_words", o_num_words_rcvd, '0);
        tick();
        start(16'h8880, 3'd7);
        for (int k = 0; k < NB; k++) beat(dv(8'h90, k));
        tick();
        chk("t6_refill_slot7", o_block_data[319:280], 40'h905A5A5A00);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
